seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle ALU.
- Adds iterative multiply and divide (shift-add / restoring, one bit per clock) behind a start/busy/done handshake, plus a high result word.
- Sits between the register file read ports and the writeback mux of the multi-cycle datapath; the control FSM stalls on busy.

Parameters:
- WIDTH, 32, operand and result width; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  operation request; sampled only in IDLE
- Aluctrl  input  4  operation select
- in_1  input  WIDTH  operand A / multiplicand / dividend
- in_2  input  WIDTH  operand B / multiplier / divisor
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result valid from this cycle
- Aluout  output  WIDTH  result low word / product low / quotient
- Aluout_hi  output  WIDTH  product high / remainder; 0 for logic and arith ops
- zeroflag  output  1  (Aluout == 0), registered with Aluout
- div_by_zero  output  1  set with done when DIV has in_2 == 0

Behaviour:
- Reset (async, reset_n low): state IDLE; busy, done, div_by_zero = 0; Aluout, Aluout_hi = 0; zeroflag = 1; counter = 0.
- Aluctrl codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (unsigned), C NOR, 8 MULT, 9 DIV.
- Any other code: result 0, single-cycle timing.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- Operands and Aluctrl are latched on the accepted start edge. Input changes while busy have no effect.
- FSM states: IDLE, CALC, FIN.
- IDLE + start, single-cycle op:
  - result registered on the same edge; next state FIN.
  - done = 1 for exactly the cycle after start (latency 1); busy stays 0.
- IDLE + start, MULT or DIV (in_2 != 0):
  - next state CALC; busy = 1 from the next cycle.
  - counter loads WIDTH and decrements once per CALC cycle, one bit per cycle.
  - On counter == 1: write Aluout/Aluout_hi, go to FIN, busy drops.
  - done is high WIDTH+1 cycles after the start edge (WIDTH busy cycles, then done).
- MULT: unsigned shift-add; {Aluout_hi, Aluout} = full 2*WIDTH product.
- DIV: unsigned restoring; Aluout = quotient, Aluout_hi = remainder.
- DIV with in_2 == 0: no iteration; FIN after 1 cycle; Aluout = all ones, Aluout_hi = in_1, div_by_zero = 1 with done.
- FIN: done = 1 for one cycle, then IDLE.
  - start is ignored in FIN; the earliest next accept is the cycle after done.
- Outputs hold their last result until the next accepted operation completes.
  - During CALC, Aluout and Aluout_hi show the previous result, not partial values.
- div_by_zero clears on the next accepted start.
- start while busy: ignored, not queued.
- Reset mid-CALC: aborts immediately, all outputs return to reset values, no done pulse.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_MD_EN.
- Defined:
  - MULT and DIV treat operands as two's complement: magnitudes are iterated, then the result sign is fixed in FIN, so latency is unchanged.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - SLT becomes signed.
  - Most-negative / -1 gives quotient = most-negative and remainder 0.
- Undefined: all operations unsigned as specified above.

Test Plan:
- Reset then idle: reset_n low mid-cycle -> outputs immediately 0, zeroflag = 1; release, no start -> busy and done stay 0.
- Single-cycle ops (WIDTH=32): in_1=FFFF_FFFF, in_2=0000_0001.
  - ADD -> Aluout=0, zeroflag=1, done 1 cycle after start.
  - SUB -> FFFF_FFFE.
  - NOR -> 0.
  - SLT (unsigned) -> 0; with macro -> 1.
- MULT: in_1=0001_0000, in_2=0001_0000 -> busy exactly 32 cycles, done at cycle 33, Aluout=0, Aluout_hi=0000_0001.
- MULT with input change: in_1=FFFF_FFFF, in_2=2, in_1 changed during busy -> Aluout_hi=1, Aluout=FFFF_FFFE.
- DIV: in_1=100, in_2=7 -> Aluout=14, Aluout_hi=2, div_by_zero=0, done at cycle 33.
- DIV by zero: in_1=1234, in_2=0 -> done after 1 cycle, Aluout=FFFF_FFFF, Aluout_hi=1234, div_by_zero=1.
- Abort and back-to-back:
  - start asserted every cycle -> accepts only in IDLE.
  - reset_n pulse at cycle 10 of a MULT -> no done; next ADD after reset completes correctly.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative multiply (shift-add) and divide
// (restoring), one bit per clock, behind a start/busy/done handshake.
// Optional macro SEQ_ALU_SIGNED_MD_EN: two's complement MULT/DIV and signed SLT.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       Aluctrl,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Aluout,
    output logic [WIDTH-1:0] Aluout_hi,
    output logic             zeroflag,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_MULT = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hC;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH-1:0] quick_result;
    logic             slt_bit;
    logic             is_mult;
    logic             is_div_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_nxt;
    logic [WIDTH-1:0] div_lo_nxt;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

`ifdef SEQ_ALU_SIGNED_MD_EN
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [2*WIDTH-1:0] prod_fixed;
`endif

    // Magnitude of an operand; identity when multiply/divide are unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
`ifdef SEQ_ALU_SIGNED_MD_EN
        return v[WIDTH-1] ? -v : v;
`else
        return v;
`endif
    endfunction

    // Decode the request and compute the single-cycle result from live inputs.
    always_comb begin
        quick_result = '0;
`ifdef SEQ_ALU_SIGNED_MD_EN
        slt_bit      = ($signed(in_1) < $signed(in_2));
`else
        slt_bit      = (in_1 < in_2);
`endif
        is_mult      = (Aluctrl == OP_MULT);
        is_div_iter  = (Aluctrl == OP_DIV) && (in_2 != '0);
        case (Aluctrl)
            OP_AND:  quick_result = in_1 & in_2;
            OP_OR:   quick_result = in_1 | in_2;
            OP_ADD:  quick_result = in_1 + in_2;
            OP_SUB:  quick_result = in_1 - in_2;
            OP_SLT:  quick_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR:  quick_result = ~(in_1 | in_2);
            default: quick_result = '0;
        endcase
    end

    // One iteration step of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb_q} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};
        div_shift  = {work_hi, work_lo[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opb_q};
        div_ok     = ~div_diff[WIDTH];
        div_hi_nxt = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_nxt = {work_lo[WIDTH-2:0], div_ok};
        if (op_q == OP_MULT) begin
            step_hi = mul_hi_nxt;
            step_lo = mul_lo_nxt;
        end else begin
            step_hi = div_hi_nxt;
            step_lo = div_lo_nxt;
        end
    end

    // Sign correction of the final iteration, applied as the result is written.
    always_comb begin
`ifdef SEQ_ALU_SIGNED_MD_EN
        prod_fixed = neg_res_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        if (op_q == OP_MULT) begin
            fin_hi = prod_fixed[2*WIDTH-1:WIDTH];
            fin_lo = prod_fixed[WIDTH-1:0];
        end else begin
            fin_hi = neg_rem_q ? -step_hi : step_hi;
            fin_lo = neg_res_q ? -step_lo : step_lo;
        end
`else
        fin_hi = step_hi;
        fin_lo = step_lo;
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic: iterative ops pass through CALC, everything else goes straight to FIN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (is_mult || is_div_iter) ? CALC : FIN;
            CALC: if (counter == CNT_W'(1)) next_state = FIN;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = (state == CALC);
        done = (state == FIN);
    end

    // Operand latching, iteration registers and the result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter     <= '0;
            op_q        <= '0;
            opb_q       <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
            Aluout      <= '0;
            Aluout_hi   <= '0;
            zeroflag    <= 1'b1;
            div_by_zero <= 1'b0;
`ifdef SEQ_ALU_SIGNED_MD_EN
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= Aluctrl;
                        div_by_zero <= 1'b0;
`ifdef SEQ_ALU_SIGNED_MD_EN
                        neg_res_q   <= in_1[WIDTH-1] ^ in_2[WIDTH-1];
                        neg_rem_q   <= in_1[WIDTH-1];
`endif
                        if (is_mult) begin
                            opb_q   <= mag(in_1);
                            work_hi <= '0;
                            work_lo <= mag(in_2);
                            counter <= CNT_W'(WIDTH);
                        end else if (is_div_iter) begin
                            opb_q   <= mag(in_2);
                            work_hi <= '0;
                            work_lo <= mag(in_1);
                            counter <= CNT_W'(WIDTH);
                        end else if (Aluctrl == OP_DIV) begin
                            Aluout      <= '1;
                            Aluout_hi   <= in_1;
                            zeroflag    <= 1'b0;
                            div_by_zero <= 1'b1;
                        end else begin
                            Aluout    <= quick_result;
                            Aluout_hi <= '0;
                            zeroflag  <= (quick_result == '0);
                        end
                    end
                end
                CALC: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        Aluout    <= fin_lo;
                        Aluout_hi <= fin_hi;
                        zeroflag  <= (fin_lo == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH = 32).
module tb_seq_alu;

    localparam int WIDTH = 32;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic             start   = 1'b0;
    logic [3:0]       Aluctrl = 4'h0;
    logic [WIDTH-1:0] in_1    = '0;
    logic [WIDTH-1:0] in_2    = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Aluout;
    logic [WIDTH-1:0] Aluout_hi;
    logic             zeroflag;
    logic             div_by_zero;

    int checks = 0;
    int errors = 0;
    int n_busy;
    logic done_seen;

`ifdef SEQ_ALU_SIGNED_MD_EN
    localparam logic [WIDTH-1:0] EXP_SLT     = 32'h0000_0001;
    localparam logic [WIDTH-1:0] EXP_MULT2HI = 32'hFFFF_FFFF;
`else
    localparam logic [WIDTH-1:0] EXP_SLT     = 32'h0000_0000;
    localparam logic [WIDTH-1:0] EXP_MULT2HI = 32'h0000_0001;
`endif

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .Aluctrl     (Aluctrl),
        .in_1        (in_1),
        .in_2        (in_2),
        .busy        (busy),
        .done        (done),
        .Aluout      (Aluout),
        .Aluout_hi   (Aluout_hi),
        .zeroflag    (zeroflag),
        .div_by_zero (div_by_zero)
    );

    // Free-running 100 MHz clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        @(negedge clock);
        start   = 1'b1;
        Aluctrl = op;
        in_1    = a;
        in_2    = b;
        @(negedge clock);
        start   = 1'b0;
    endtask

    task automatic waitBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Directed test sequence.
    initial begin
        $display("[TB] seq_alu directed test start");

        // Asynchronous reset asserted mid-cycle
        #3 reset_n = 1'b0;
        #1;
        checkOutput("rst Aluout",   Aluout, 32'h0);
        checkOutput("rst Aluout_hi", Aluout_hi, 32'h0);
        checkOutput("rst zeroflag", {31'b0, zeroflag}, 32'h1);
        checkOutput("rst busy",     {31'b0, busy}, 32'h0);
        checkOutput("rst done",     {31'b0, done}, 32'h0);
        checkOutput("rst dbz",      {31'b0, div_by_zero}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("idle busy", {31'b0, busy}, 32'h0);
        checkOutput("idle done", {31'b0, done}, 32'h0);

        // Single-cycle operations
        applyStimulus(4'h2, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("add done",     {31'b0, done}, 32'h1);
        checkOutput("add busy",     {31'b0, busy}, 32'h0);
        checkOutput("add result",   Aluout, 32'h0);
        checkOutput("add zeroflag", {31'b0, zeroflag}, 32'h1);
        checkOutput("add hi",       Aluout_hi, 32'h0);
        @(negedge clock);
        checkOutput("add done pulse", {31'b0, done}, 32'h0);

        applyStimulus(4'h6, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("sub result",   Aluout, 32'hFFFF_FFFE);
        checkOutput("sub zeroflag", {31'b0, zeroflag}, 32'h0);

        applyStimulus(4'hC, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("nor result",   Aluout, 32'h0);

        applyStimulus(4'h7, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("slt result",   Aluout, EXP_SLT);

        applyStimulus(4'h0, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("and result",   Aluout, 32'h1);

        applyStimulus(4'h3, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("undef result", Aluout, 32'h0);
        checkOutput("undef done",   {31'b0, done}, 32'h1);

        applyStimulus(4'h1, 32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("or result",    Aluout, 32'hFFFF_FFFF);

        // MULT 0x10000 * 0x10000
        applyStimulus(4'h8, 32'h0001_0000, 32'h0001_0000);
        checkOutput("mult busy",      {31'b0, busy}, 32'h1);
        checkOutput("mult hold lo",   Aluout, 32'hFFFF_FFFF);
        checkOutput("mult hold done", {31'b0, done}, 32'h0);
        waitBusy(n_busy);
        checkOutput("mult busy cycles", n_busy, 32'd32);
        checkOutput("mult done",      {31'b0, done}, 32'h1);
        checkOutput("mult lo",        Aluout, 32'h0);
        checkOutput("mult hi",        Aluout_hi, 32'h1);
        checkOutput("mult zeroflag",  {31'b0, zeroflag}, 32'h1);

        // MULT with inputs changed and start pulsed while busy
        applyStimulus(4'h8, 32'hFFFF_FFFF, 32'h0000_0002);
        in_1    = 32'h1234_5678;
        in_2    = 32'h0000_0009;
        Aluctrl = 4'h2;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        waitBusy(n_busy);
        checkOutput("mult2 busy cycles", n_busy, 32'd31);
        checkOutput("mult2 done", {31'b0, done}, 32'h1);
        checkOutput("mult2 lo",   Aluout, 32'hFFFF_FFFE);
        checkOutput("mult2 hi",   Aluout_hi, EXP_MULT2HI);

        // DIV 100 / 7
        applyStimulus(4'h9, 32'd100, 32'd7);
        waitBusy(n_busy);
        checkOutput("div busy cycles", n_busy, 32'd32);
        checkOutput("div done", {31'b0, done}, 32'h1);
        checkOutput("div quot", Aluout, 32'd14);
        checkOutput("div rem",  Aluout_hi, 32'd2);
        checkOutput("div dbz",  {31'b0, div_by_zero}, 32'h0);

        // DIV by zero
        applyStimulus(4'h9, 32'd1234, 32'd0);
        checkOutput("dbz done", {31'b0, done}, 32'h1);
        checkOutput("dbz busy", {31'b0, busy}, 32'h0);
        checkOutput("dbz quot", Aluout, 32'hFFFF_FFFF);
        checkOutput("dbz rem",  Aluout_hi, 32'd1234);
        checkOutput("dbz flag", {31'b0, div_by_zero}, 32'h1);
        applyStimulus(4'h2, 32'd40, 32'd2);
        checkOutput("dbz clear", {31'b0, div_by_zero}, 32'h0);
        checkOutput("dbz next add", Aluout, 32'd42);

        // start held every cycle: accepted only from IDLE
        @(negedge clock);
        start   = 1'b1;
        Aluctrl = 4'h2;
        in_1    = 32'd1;
        in_2    = 32'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput($sformatf("b2b done %0d", i), {31'b0, done}, {31'b0, (i % 2 == 0)});
        end
        start = 1'b0;
        checkOutput("b2b result", Aluout, 32'd3);

        // Reset during a MULT aborts without a done pulse
        applyStimulus(4'h8, 32'd3, 32'd5);
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort busy",     {31'b0, busy}, 32'h0);
        checkOutput("abort Aluout",   Aluout, 32'h0);
        checkOutput("abort hi",       Aluout_hi, 32'h0);
        checkOutput("abort zeroflag", {31'b0, zeroflag}, 32'h1);
        @(negedge clock);
        reset_n   = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) done_seen = 1'b1;
        end
        checkOutput("abort no done", {31'b0, done_seen}, 32'h0);
        applyStimulus(4'h2, 32'd5, 32'd6);
        checkOutput("post-abort done", {31'b0, done}, 32'h1);
        checkOutput("post-abort add",  Aluout, 32'd11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
